branch_resolver: RTL
====================

Name: branch_resolver

Overview:
Resolves branches in the MEM stage and closes the loop with the fetch-side 4-entry branch target buffer. It compares the actual branch outcome with the prediction carried down the pipeline. On a mispredict it issues a one-cycle flush and the correct redirect PC. It also produces the BTB write port, with 2-bit saturating counters held in an internal shadow table, plus branch and mispredict statistics.

Parameters:
ENTRIES, 4, number of BTB entries; index is br_pc[3:2], tag is br_pc[31:4].
CNT_W, 2, width of each saturating direction counter.
STAT_W, 32, width of the statistics counters.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
stall  in  1  MEM stage is not advancing this cycle
br_valid  in  1  a branch or jump is resolving in MEM
br_pc  in  32  PC of the resolving branch
br_taken  in  1  actual direction of the branch
br_target  in  32  actual taken target
pred_taken  in  1  fetch predicted taken (BTB hit and counter MSB set)
pred_target  in  32  NPC used by fetch when pred_taken=1
flush  out  1  squash IF/ID/EX and redirect fetch
redirect_pc  out  32  correct next PC, valid while flush=1
btb_wen  out  1  BTB write strobe
btb_widx  out  2  BTB entry index to write
btb_wtag  out  28  tag to write
btb_wtarget  out  32  target to write
btb_wcnt  out  2  counter value to write
branch_count  out  STAT_W  accepted branches, saturating
mispredict_count  out  STAT_W  accepted mispredicts, saturating

Behaviour:
- Accept condition: accept = br_valid & !stall & !flush. A branch arriving while flush=1 is wrong-path and is ignored completely: no flush, no write, no count.
- Mispredict condition: mis = (pred_taken != br_taken) | (br_taken & pred_taken & (pred_target != br_target)).
- Correct next PC: br_taken ? br_target : br_pc + 4. The addition is 32-bit and wraps modulo 2^32.
- Latency: all outputs are registered, one cycle after accept.
  - flush = accept & mis. flush is a single-cycle pulse and is cleared the cycle after it is set.
  - redirect_pc = correct next PC when flush is set, otherwise 0.
- Shadow table: per entry it holds valid, tag[27:0], target[31:0] and cnt[1:0].
- Shadow hit (entry valid and tag equal):
  - cnt updates: taken increments and saturates at 2'b11; not-taken decrements and saturates at 2'b00.
  - target becomes br_target if taken, otherwise it is retained.
  - A write is always emitted, even when cnt saturates unchanged.
- Shadow miss:
  - If taken: allocate or overwrite the entry with valid=1, tag, target=br_target, cnt=2'b10.
  - If not taken: no allocation and no write.
- Write port timing:
  - btb_wen pulses for one cycle, in the same cycle the shadow entry is updated.
  - btb_w* carry the new entry contents and hold their values when btb_wen=0.
- Statistics:
  - branch_count increments on every accept.
  - mispredict_count increments on accept & mis.
  - Both saturate at all-ones.
- stall=1: there is no accept. flush and btb_wen still drop after their single cycle.
- Reset:
  - All outputs, shadow valid bits, counters and statistics are cleared to 0.
  - A pending flush or write is dropped.
  - RST wins over a simultaneous br_valid.

Test Plan:
- Cold miss, taken: reset, then pc=0x00000040, taken, target=0x00000100, pred_taken=0 -> next cycle flush=1, redirect_pc=0x100, btb_wen=1, idx=0, tag=0x0000004, wtarget=0x100, cnt=10; counts 1/1.
- Training: repeat the same branch twice with taken=1, pred_taken=1, pred_target=0x100 -> flush=0 both times, cnt=11 then 11 (saturated), btb_wen=1 each time; counts 3/1.
- Decay and redirect: pc=0x40, not taken, pred_taken=1 -> flush=1, redirect_pc=0x44, cnt=10. Two more not-taken with pred_taken=0 -> cnt=01, then 00; flush=0.
- Wrong target: pc=0x40, taken, target=0x200, pred_taken=1, pred_target=0x100 -> flush=1, redirect_pc=0x200, wtarget=0x200.
- Wrong-path and stall: a branch presented in the flush cycle, and a branch with stall=1 -> no flush, no btb_wen, counts unchanged. Cold miss, not taken, pred_taken=0 -> btb_wen=0, flush=0, branch_count increments.
- Alias and reset: after entry 0 is trained, pc=0x140 taken to 0x300 -> idx=0, tag=0x0000014, cnt=10, flush=1. Assert RST together with br_valid -> all outputs 0, and the next access to pc=0x40 is treated as a miss.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver: MEM-stage branch resolution, mispredict flush/redirect and BTB training
module branch_resolver #(
  parameter int ENTRIES = 4,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       stall,
  input  logic                       br_valid,
  input  logic [31:0]                br_pc,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       pred_taken,
  input  logic [31:0]                pred_target,
  output logic                       flush,
  output logic [31:0]                redirect_pc,
  output logic                       btb_wen,
  output logic [$clog2(ENTRIES)-1:0] btb_widx,
  output logic [29-$clog2(ENTRIES):0] btb_wtag,
  output logic [31:0]                btb_wtarget,
  output logic [CNT_W-1:0]           btb_wcnt,
  output logic [STAT_W-1:0]          branch_count,
  output logic [STAT_W-1:0]          mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b1, {(CNT_W-1){1'b0}}};

  logic               r_flush;
  logic [31:0]        r_redirect_pc;
  logic               r_wen;
  logic [IDX_W-1:0]   r_widx;
  logic [TAG_W-1:0]   r_wtag;
  logic [31:0]        r_wtarget;
  logic [CNT_W-1:0]   r_wcnt;
  logic [STAT_W-1:0]  r_branch_count;
  logic [STAT_W-1:0]  r_mispredict_count;
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];

  logic               w_accept;
  logic               w_mis;
  logic [31:0]        w_next_pc;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_old;
  logic [CNT_W-1:0]   w_cnt_new;
  logic [31:0]        w_target_new;
  logic               w_write;
  logic               w_unused;

  assign w_unused = ^br_pc[1:0];

  // Branches arriving during a flush are on the wrong path and are dropped.
  always_comb begin
    w_accept     = br_valid & ~stall & ~r_flush;
    w_mis        = (pred_taken != br_taken) | (br_taken & pred_taken & (pred_target != br_target));
    w_next_pc    = br_taken ? br_target : br_pc + 32'd4;
    w_idx        = br_pc[IDX_W+1:2];
    w_tag        = br_pc[31:IDX_W+2];
    w_hit        = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    w_cnt_old    = r_cnt[w_idx];
    w_cnt_new    = !w_hit ? CNT_INIT :
                   br_taken ? ((w_cnt_old == CNT_MAX) ? w_cnt_old : w_cnt_old + CNT_W'(1)) :
                   ((w_cnt_old == '0) ? w_cnt_old : w_cnt_old - CNT_W'(1));
    w_target_new = br_taken ? br_target : r_target[w_idx];
    w_write      = w_accept & (w_hit | br_taken);
  end

  // Flush/redirect pulse and statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_flush            <= 1'b0;
      r_redirect_pc      <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_flush            <= w_accept & w_mis;
      r_redirect_pc      <= (w_accept & w_mis) ? w_next_pc : 32'd0;
      r_branch_count     <= (w_accept && r_branch_count != '1) ? r_branch_count + STAT_W'(1) : r_branch_count;
      r_mispredict_count <= (w_accept && w_mis && r_mispredict_count != '1) ?
                            r_mispredict_count + STAT_W'(1) : r_mispredict_count;
    end
  end

  // BTB write port: strobe pulses, payload holds last written entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wen     <= 1'b0;
      r_widx    <= '0;
      r_wtag    <= '0;
      r_wtarget <= '0;
      r_wcnt    <= '0;
      r_valid   <= '0;
    end else begin
      r_wen <= w_write;
      if (w_write) begin
        r_widx           <= w_idx;
        r_wtag           <= w_tag;
        r_wtarget        <= w_target_new;
        r_wcnt           <= w_cnt_new;
        r_valid[w_idx]   <= 1'b1;
      end
    end
  end

  // Shadow payload is only meaningful behind a valid bit, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (w_write && !RST) begin
      r_tag[w_idx]    <= w_tag;
      r_target[w_idx] <= w_target_new;
      r_cnt[w_idx]    <= w_cnt_new;
    end
  end

  assign flush            = r_flush;
  assign redirect_pc      = r_redirect_pc;
  assign btb_wen          = r_wen;
  assign btb_widx         = r_widx;
  assign btb_wtag         = r_wtag;
  assign btb_wtarget      = r_wtarget;
  assign btb_wcnt         = r_wcnt;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
endmodule
